// File: rtl/top_mod_pkg.sv
`default_nettype none
// ============================================================================
// Module      : top_mod_pkg
// Description : Shared types and constants for the keyed tag engine. It holds
//               the FSM state enum, the default key and round count, and the
//               active-low 7-segment hex encodings with their decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package top_mod_pkg;

    // Tag engine sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } state_e;

    localparam logic [31:0] C_DEFAULT_KEY    = 32'h5A5A_C3C3;
    localparam int          C_DEFAULT_ROUNDS = 16;

    // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] C_SEG_0     = 7'b1000000;
    localparam logic [6:0] C_SEG_1     = 7'b1111001;
    localparam logic [6:0] C_SEG_2     = 7'b0100100;
    localparam logic [6:0] C_SEG_3     = 7'b0110000;
    localparam logic [6:0] C_SEG_4     = 7'b0011001;
    localparam logic [6:0] C_SEG_5     = 7'b0010010;
    localparam logic [6:0] C_SEG_6     = 7'b0000010;
    localparam logic [6:0] C_SEG_7     = 7'b1111000;
    localparam logic [6:0] C_SEG_8     = 7'b0000000;
    localparam logic [6:0] C_SEG_9     = 7'b0010000;
    localparam logic [6:0] C_SEG_A     = 7'b0001000;
    localparam logic [6:0] C_SEG_B     = 7'b0000011;
    localparam logic [6:0] C_SEG_C     = 7'b1000110;
    localparam logic [6:0] C_SEG_D     = 7'b0100001;
    localparam logic [6:0] C_SEG_E     = 7'b0000110;
    localparam logic [6:0] C_SEG_F     = 7'b0001110;
    localparam logic [6:0] C_SEG_BLANK = 7'b1111111;
    localparam logic [7:0] C_AN_OFF    = 8'hFF;

    // Map one hex nibble to its cathode pattern
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = C_SEG_0;
            4'h1:    seg = C_SEG_1;
            4'h2:    seg = C_SEG_2;
            4'h3:    seg = C_SEG_3;
            4'h4:    seg = C_SEG_4;
            4'h5:    seg = C_SEG_5;
            4'h6:    seg = C_SEG_6;
            4'h7:    seg = C_SEG_7;
            4'h8:    seg = C_SEG_8;
            4'h9:    seg = C_SEG_9;
            4'hA:    seg = C_SEG_A;
            4'hB:    seg = C_SEG_B;
            4'hC:    seg = C_SEG_C;
            4'hD:    seg = C_SEG_D;
            4'hE:    seg = C_SEG_E;
            default: seg = C_SEG_F;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/top_mod_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan
// Description : Eight-digit multiplexed hex display driver. A free-running
//               scan counter selects the digit from its top three bits; the
//               display is blanked whenever enable is low.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan
    import top_mod_pkg::*;
#(
    parameter int REFRESH_BITS = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] value,
    output logic [6:0]  Seg,
    output logic [7:0]  An
);

    logic [REFRESH_BITS-1:0] scan_q;
    logic [REFRESH_BITS-1:0] scan_d;
    logic [2:0]              w_digit;
    logic [3:0]              w_nibble;

    assign w_digit  = scan_q[REFRESH_BITS-1 -: 3];
    assign w_nibble = value[{w_digit, 2'b00} +: 4];

    // Scan counter advances every cycle and wraps naturally
    always_comb begin
        scan_d = scan_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
    end

    // Scan counter register, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q <= '0;
        end else begin
            scan_q <= scan_d;
        end
    end

    // Select the active anode and decode its nibble, or blank the display
    always_comb begin
        An  = C_AN_OFF;
        Seg = C_SEG_BLANK;
        if (enable) begin
            An[w_digit] = 1'b0;
            Seg         = hex_to_seg(w_nibble);
        end
    end

endmodule

`default_nettype wire

// File: rtl/top_mod.sv
`default_nettype none
// ============================================================================
// Module      : top_mod
// Description : Keyed 32-bit tag engine. Loads a 16-bit message from the
//               switches, runs ROUNDS rotate/add/xor compression rounds,
//               flags a match against EXPECTED and shows the tag on an
//               eight-digit 7-segment display.
// Revision    : 1.0 - initial release
// ============================================================================
module top_mod
    import top_mod_pkg::*;
#(
    parameter logic [31:0] KEY          = C_DEFAULT_KEY,
    parameter int          ROUNDS       = C_DEFAULT_ROUNDS,
    parameter logic [31:0] EXPECTED     = 32'h0000_0000,
    parameter int          REFRESH_BITS = 17
) (
    input  logic        clk,
    input  logic        rst,
    output logic        done,
    output logic        TAG,
    input  logic [15:0] SW,
    output logic [6:0]  Seg,
    output logic [7:0]  An
);

    localparam logic [7:0] C_LAST_ROUND = 8'(ROUNDS - 1);

    state_e      state_q,  state_d;
    logic [31:0] s_q,      s_d;
    logic [31:0] result_q, result_d;
    logic [15:0] msg_q,    msg_d;
    logic [7:0]  r_q,      r_d;
    logic        done_q,   done_d;
    logic        tag_q,    tag_d;

    logic [31:0] w_mix;
    logic [31:0] w_s_step;

    // One compression round: rotate left by 3, add the keyed message, fold in round index
    assign w_mix    = KEY ^ {msg_q, msg_q};
    assign w_s_step = ({s_q[28:0], s_q[31:29]} + w_mix) ^ {24'b0, r_q};

    // Next-state logic for sequencing, datapath and registered status outputs
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        result_d = result_q;
        msg_d    = msg_q;
        r_d      = r_q;
        case (state_q)
            IDLE: begin
                state_d = LOAD;
            end
            LOAD: begin
                msg_d   = SW;
                s_d     = {SW, ~SW};
                r_d     = 8'd0;
                state_d = RUN;
            end
            RUN: begin
                s_d = w_s_step;
                r_d = r_q + 8'd1;
                if (r_q == C_LAST_ROUND) begin
                    result_d = w_s_step;
                    state_d  = FIN;
                end
            end
            FIN: begin
                state_d = FIN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Status flags track the next state so they change on the same edge as the FSM
        done_d = (state_d == FIN);
        tag_d  = (state_d == FIN) && (result_d == EXPECTED);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            s_q      <= '0;
            result_q <= '0;
            msg_q    <= '0;
            r_q      <= '0;
            done_q   <= 1'b0;
            tag_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            result_q <= result_d;
            msg_q    <= msg_d;
            r_q      <= r_d;
            done_q   <= done_d;
            tag_q    <= tag_d;
        end
    end

    assign done = done_q;
    assign TAG  = tag_q;

    seg7_scan #(
        .REFRESH_BITS (REFRESH_BITS)
    ) u_seg7_scan (
        .clk    (clk),
        .rst    (rst),
        .enable (done_q),
        .value  (result_q),
        .Seg    (Seg),
        .An     (An)
    );

endmodule

`default_nettype wire

// File: tb/tb_top_mod.sv
`default_nettype none
// ============================================================================
// Module      : tb_top_mod
// Description : Self-checking bench for top_mod. Random and directed messages
//               are compared against a behavioural tag model; latency, TAG,
//               display scan order and digit decoding are all checked.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_top_mod;

    localparam logic [31:0] TB_KEY    = 32'h5A5A_C3C3;
    localparam int          TB_ROUNDS = 16;

    // Behavioural tag model computed straight from the round rule
    function automatic logic [31:0] golden(input logic [15:0] sw);
        logic [31:0] s;
        s = {sw, ~sw};
        for (int r = 0; r < TB_ROUNDS; r++) begin
            s = (((s << 3) | (s >> 29)) + (TB_KEY ^ {sw, sw})) ^ 32'(r % 256);
        end
        return s;
    endfunction

    localparam logic [31:0] GOLD0 = golden(16'h0000);

    // Reference cathode table, active-low {g..a}
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    logic        clk;
    logic        rst;
    logic        done;
    logic        TAG;
    logic [15:0] SW;
    logic [6:0]  Seg;
    logic [7:0]  An;

    int n_checks = 0;
    int n_fail   = 0;
    int edges    = 0;

    top_mod #(
        .EXPECTED     (GOLD0),
        .REFRESH_BITS (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .done (done),
        .TAG  (TAG),
        .SW   (SW),
        .Seg  (Seg),
        .An   (An)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample just after it
    task automatic step();
        @(posedge clk);
        #1;
        edges++;
    endtask

    // One-cycle reset pulse with the given message on the switches
    task automatic apply_reset(input logic [15:0] sw);
        @(negedge clk);
        rst = 1'b1;
        SW  = sw;
        @(negedge clk);
        rst   = 1'b0;
        edges = 0;
        check_value("rst_done", 32'(done), 32'd0);
        check_value("rst_tag",  32'(TAG),  32'd0);
        check_value("rst_an",   32'(An),   32'hFF);
        check_value("rst_seg",  32'(Seg),  32'h7F);
    endtask

    // Wait for done with a bounded edge budget; optionally scramble SW after LOAD
    task automatic wait_done(input bit scramble);
        while (!done && edges < 100) begin
            step();
            if (scramble && edges >= 2 && !done) SW = 16'($urandom);
        end
        check_value("latency", 32'(edges), 32'd18);
    endtask

    // Check status and one full scan of the eight digits
    task automatic check_display(input logic [31:0] exp);
        int         d;
        logic [7:0] an_exp;
        check_value("done", 32'(done), 32'd1);
        check_value("tag",  32'(TAG),  32'(exp == GOLD0));
        repeat (16) begin
            step();
            d      = (edges % 16) / 2;
            an_exp = ~(8'd1 << d);
            check_value("scan_an",  32'(An),  32'(an_exp));
            check_value("scan_seg", 32'(Seg), 32'(seg_of(exp[d*4 +: 4])));
        end
    endtask

    task automatic run_case(input logic [15:0] sw, input bit scramble);
        apply_reset(sw);
        wait_done(scramble);
        check_display(golden(sw));
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        rst = 1'b1;
        SW  = 16'h0000;
        repeat (2) @(negedge clk);

        run_case(16'h0000, 1'b0);
        run_case(16'hBEEF, 1'b0);
        run_case(16'h0001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_case(16'($urandom), 1'b0);
        end

        // Switch changes during RUN must not disturb the loaded message
        for (int i = 0; i < 3; i++) begin
            run_case(16'($urandom), 1'b1);
        end

        // Abort at round 5 and restart with a different message
        a = 16'($urandom);
        b = a ^ 16'h5A3C;
        apply_reset(a);
        repeat (7) step();
        check_value("midrun_done", 32'(done), 32'd0);
        run_case(b, 1'b0);

        // Abort from FIN
        run_case(16'h0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/top_mod.md
TOP_MOD -- requirements
Module: top_mod

Interface
REQ-001 SHALL have parameter KEY, default 32'h5A5A_C3C3: 32-bit secret key mixed into every round.
REQ-002 SHALL have parameter ROUNDS, default 16: number of compression rounds (range 1..255).
REQ-003 SHALL have parameter EXPECTED, default 32'h0000_0000: reference tag for the TAG comparison.
REQ-004 SHALL have parameter REFRESH_BITS, default 17: width of the display scan counter (about 763 Hz digit rate at 100 MHz).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port done, output, 1 bit: tag computation complete.
REQ-008 SHALL have port TAG, output, 1 bit: the computed tag equals EXPECTED.
REQ-009 SHALL have port SW, input, 16 bits: message word from the board switches.
REQ-010 SHALL have port Seg, output, 7 bits: active-low cathodes {g,f,e,d,c,b,a}.
REQ-011 SHALL have port An, output, 8 bits: active-low digit anodes; An[0] is the rightmost digit.
REQ-012 SHALL keep the port order clk, rst, done, TAG, SW, Seg, An.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, RUN, FIN.
- Reset enters IDLE.
- IDLE -> LOAD unconditionally.
- LOAD -> RUN.
- RUN -> FIN after ROUNDS cycles.
- FIN holds until rst.
REQ-014 In LOAD, SHALL register msg = SW and set state s = {SW, ~SW}, round counter r = 0.
REQ-015 SW changes after LOAD SHALL NOT affect the result.
REQ-016 In each RUN cycle, SHALL compute s <= (rotl(s,3) + (KEY ^ {msg,msg})) ^ {24'b0, r}, then r <= r+1.
- Addition is 32-bit modulo 2^32.
- r is 8 bits.
REQ-017 On the RUN -> FIN transition, SHALL latch result = final s.
REQ-018 done SHALL be 1 exactly while in FIN.
- done first rises after the (ROUNDS+2)th rising edge after the first edge sampling rst=0 (18 edges by default).
REQ-019 TAG SHALL be 1 only when done=1 and result == EXPECTED; otherwise 0.
REQ-020 SHALL keep a free-running scan counter of REFRESH_BITS bits.
- Digit index = its top 3 bits.
- Digit i drives An[i]=0 with all other anodes 1, and shows hex nibble result[4i+3:4i].
REQ-021 When done=0, SHALL blank the display: An=8'hFF, Seg=7'h7F.
REQ-022 Hex segment encoding, active-low {g..a}:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110
REQ-023 Reset asserted mid-RUN or in FIN SHALL abort the computation; the whole sequence restarts on release.

Reset
REQ-024 While rst=1 at a clock edge, the following SHALL be cleared to 0: state (IDLE), s, msg, r, result, scan counter.
REQ-025 During and after reset until FIN: done=0, TAG=0, An=8'hFF, Seg=7'h7F.
REQ-026 A 1-cycle rst pulse SHALL be sufficient to restart.

Structure
REQ-027 SHALL place the FSM state enum, the segment-encoding constants and the default KEY/ROUNDS in a shared package top_mod_pkg.
REQ-028 SHALL implement display scanning and hex decoding in one sub-module seg7_scan (inputs clk, rst, enable, value[31:0]; outputs Seg, An).
- The tag core stays in top_mod.

Verification
REQ-029 SHALL verify reset: rst=1 for 1 cycle, SW=16'h0000 -> done=0, TAG=0, An=8'hFF, Seg=7'h7F.
REQ-030 SHALL verify latency: after rst release with default ROUNDS=16 -> done=1 after exactly 18 edges.
- result matches a bit-exact golden model of REQ-016 for SW=16'h0000 and 16'hBEEF.
REQ-031 SHALL verify TAG: set EXPECTED to the golden tag for SW=16'h0000 -> TAG=1 once done=1; with SW=16'h0001 -> TAG=0.
REQ-032 SHALL verify the display, with REFRESH_BITS=4 for simulation:
- An cycles FE, FD, FB, F7, EF, DF, BF, 7F, each held 2 clocks.
- Seg matches REQ-022 for each nibble of result.
REQ-033 SHALL verify mid-run reset: assert rst at RUN round 5, release, change SW -> done returns 18 edges later with the tag for the new SW.
REQ-034 SHALL verify SW isolation: toggle SW during RUN -> result is unchanged from the LOAD-time value.
